// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and the arbiter FSM state encoding.
package alu_pkg;

    localparam logic [3:0] ADD  = 4'b0000;
    localparam logic [3:0] INC  = 4'b0001;
    localparam logic [3:0] SUB  = 4'b0010;
    localparam logic [3:0] DEC  = 4'b0011;
    localparam logic [3:0] MUL  = 4'b0100;
    localparam logic [3:0] DIV  = 4'b0101;
    localparam logic [3:0] SHL  = 4'b0110;
    localparam logic [3:0] SHR  = 4'b0111;
    localparam logic [3:0] AND  = 4'b1000;
    localparam logic [3:0] OR   = 4'b1001;
    localparam logic [3:0] INV  = 4'b1010;
    localparam logic [3:0] NAND = 4'b1011;
    localparam logic [3:0] NOR  = 4'b1100;
    localparam logic [3:0] XOR  = 4'b1101;
    localparam logic [3:0] XNOR = 4'b1110;
    localparam logic [3:0] BUF  = 4'b1111;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } arb_state_t;

endpackage

// File: rtl/arb2_rr.sv
// Two-way grant logic. With ALU_ARB_RR_EN defined a 1-bit pointer gives
// round-robin priority; otherwise requester 0 always wins ties.
module arb2_rr
    import alu_pkg::*;
(
`ifdef ALU_ARB_RR_EN
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
`endif
    input  logic [1:0] req,
    output logic [1:0] gnt
);

`ifdef ALU_ARB_RR_EN
    logic ptr;

    // Pointer always points at the requester that did not win the last grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= gnt[0];
        end
    end

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end
`else
    always_comb begin
        gnt = req[0] ? 2'b01 : {req[1], 1'b0};
    end
`endif

endmodule

// File: rtl/alu_req_arbiter.sv
// Two-requester scheduler for the shared command-driven ALU.
// Arbitration is round-robin when ALU_ARB_RR_EN is defined, fixed priority otherwise.
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int RES_W   = 16,
    parameter int CMD_W   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [CMD_W-1:0]  req0_cmd,
    input  logic [CMD_W-1:0]  req1_cmd,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [RES_W-1:0]  rsp_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CMD_W-1:0]  alu_cmd,
    output logic              alu_en,
    input  logic [RES_W-1:0]  alu_dout,
    output logic              busy
);

    localparam logic [3:0] CNT_LAST = 4'(ALU_LAT - 1);

    arb_state_t state;
    logic [3:0] cnt;
    logic       grant_idx;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       accept;

    // Requests are only visible to the arbiter while idle and out of reset,
    // so ready can never be seen during EXEC or in a reset cycle.
    assign req        = {req1_valid, req0_valid} & {2{(state == IDLE) && !rst}};
    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign accept     = |gnt;

    arb2_rr u_arb (
`ifdef ALU_ARB_RR_EN
        .clk     (clk),
        .rst     (rst),
        .advance (accept),
`endif
        .req     (req),
        .gnt     (gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            grant_idx  <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_cmd    <= CMD_W'(ADD);
            alu_en     <= 1'b0;
            busy       <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_data   <= '0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a     <= gnt[1] ? req1_a   : req0_a;
                        alu_b     <= gnt[1] ? req1_b   : req0_b;
                        alu_cmd   <= gnt[1] ? req1_cmd : req0_cmd;
                        grant_idx <= gnt[1];
                        cnt       <= '0;
                        alu_en    <= 1'b1;
                        busy      <= 1'b1;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    // Operands stay on the ALU pins after completion.
                    if (cnt == CNT_LAST) begin
                        rsp_data   <= alu_dout;
                        rsp0_valid <= !grant_idx;
                        rsp1_valid <= grant_idx;
                        cnt        <= '0;
                        alu_en     <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Two-requester scheduler that shares the 8-bit command-driven ALU (operands a/b, 4-bit command, enable, 16-bit d_out) between independent clients.
- Accepts one operation at a time over a valid/ready handshake.
- Drives the ALU operand, command and enable inputs for a programmable number of cycles, then captures d_out.
- Returns the result to the originating requester as a one-cycle response pulse.
- Sits between the ALU and its client blocks; the ALU itself is unchanged.

## Interface
Parameters:
- DATA_W, 8, operand width (ALU a/b)
- RES_W, 16, result width (ALU d_out)
- CMD_W, 4, ALU command width
- ALU_LAT, 1, cycles alu_en is held before d_out is sampled (legal range 1–15)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- req0_valid / req1_valid  in  1  requester has an operation
- req0_ready / req1_ready  out  1  operation accepted this cycle
- req0_a, req0_b / req1_a, req1_b  in  DATA_W  operands
- req0_cmd / req1_cmd  in  CMD_W  ALU opcode
- rsp0_valid / rsp1_valid  out  1  one-cycle result pulse, no backpressure
- rsp_data  out  RES_W  result, valid only while a rsp*_valid is high
- alu_a, alu_b  out  DATA_W  ALU operands
- alu_cmd  out  CMD_W  ALU command
- alu_en  out  1  ALU enable
- alu_dout  in  RES_W  ALU result
- busy  out  1  high in EXEC state

## Operation
- FSM states:
  - IDLE: wait for a request.
  - EXEC: operation in flight; a counter runs from 0 to ALU_LAT-1.
- IDLE behaviour:
  - If any reqN_valid is high, the arbiter picks a winner and asserts that reqN_ready combinationally in the same cycle.
  - On the clock edge, the winner's a/b/cmd are latched into alu_a/alu_b/alu_cmd, the grant index is stored, and the FSM moves to EXEC.
- EXEC behaviour:
  - alu_en=1 and both ready signals are 0.
  - When the counter reaches ALU_LAT-1, alu_dout is registered into rsp_data, rsp{grant}_valid is set for the next cycle, alu_en drops and the FSM returns to IDLE.
- Arbitration: round-robin with a 1-bit priority pointer.
  - Simultaneous requests go to the pointer's requester.
  - After any grant, the pointer moves to the other requester.
  - A lone request wins regardless of the pointer.
- Data handling:
  - alu_a/b/cmd hold their last issued values outside EXEC.
  - rsp_data holds its last value between pulses.
  - Opcodes pass through unchecked; divide-by-zero and other ALU results are forwarded as-is.
- Reset values: FSM=IDLE, counter=0, pointer=requester 0, alu_a=alu_b=0, alu_cmd=0 (ADD), alu_en=0, rsp*_valid=0, rsp_data=0, busy=0, req*_ready=0.
- Reset during EXEC aborts the operation: no response is issued and the grant is discarded.
- rst has priority over every other event in the same cycle.

## Timing
- Accept at edge T (valid&&ready in cycle T-1): EXEC occupies cycles T … T+ALU_LAT-1 with alu_en=1.
- alu_dout is sampled at the end of cycle T+ALU_LAT-1; rsp pulse is in cycle T+ALU_LAT.
- The FSM is IDLE in cycle T+ALU_LAT, so a new accept can happen in the same cycle as the response pulse.
- Throughput is one operation per ALU_LAT+1 cycles.
- A requester may hold valid across its own response; it is re-arbitrated normally.

## Configuration
- ALU_ARB_RR_EN defined: round-robin arbitration as described above.
- ALU_ARB_RR_EN undefined: fixed priority; requester 0 always wins simultaneous requests, and the pointer logic is removed.

## Structure
- Shared package alu_pkg holds:
  - opcode constants ADD=0000, INC=0001, SUB=0010, DEC=0011, MUL=0100, DIV=0101, SHL=0110, SHR=0111, AND=1000, OR=1001, INV=1010, NAND=1011, NOR=1100, XOR=1101, XNOR=1110, BUF=1111;
  - FSM state encoding (IDLE=0, EXEC=1).
- Sub-module arb2_rr: 2-way grant logic plus the pointer register; it contains the ALU_ARB_RR_EN switch.

## Test plan
- Single request: req0 ADD a=24, b=12 → req0_ready for 1 cycle; alu_en high for ALU_LAT cycles; rsp0_valid pulse with rsp_data=36.
- Simultaneous requests after reset: req0 SUB 32,10 and req1 MUL 2,10 → req0 granted first, rsp0 data=22; then req1 granted, rsp1 data=20; no overlap on alu_en.
- Fairness with RR on: both valid held continuously for 6 operations → grants alternate 0,1,0,1,0,1. With macro undefined → all six go to req0.
- Reset mid-EXEC (ALU_LAT=3, assert rst in the 2nd EXEC cycle) → no rsp pulse; all outputs at reset values next cycle; pointer=0.
- Latency/back-to-back with ALU_LAT=3: req1 DIV 2,10 then ADD 2,10 held valid → second accept happens in the same cycle as the first rsp1 pulse; pulses are 4 cycles apart.
